// File: rtl/hs32_timer_mc.sv
// hs32_timer_mc: multi-channel compare timer with prescaler, external clock input and PWM outputs
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clk_source         tick source: off, clk/1, /8, /64, /256, /1024, ext rise, ext fall
//   ext_clk            asynchronous external count input
//   timer_mode         0 free-run, 1 clear-on-match, 2 one-shot, 3 up/down
//   output_mode        2 bits per channel: off, toggle, clear-on-match/set-at-bottom, set-on-match/clear-at-bottom
//   match              compare value per channel at [i*WIDTH +: WIDTH]; channel 0 is TOP
//   load, load_value   preload pulse, wins over a tick
//   start              re-arms a halted one-shot
//   count              counter value
//   int_match, int_ovf registered match / bottom event pulses
//   io                 registered compare outputs
module hs32_timer_mc #(
   parameter int WIDTH = 32,
   parameter int NCH   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           clk_source,
   input  logic                 ext_clk,
   input  logic [1:0]           timer_mode,
   input  logic [2*NCH-1:0]     output_mode,
   input  logic [WIDTH*NCH-1:0] match,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_value,
   input  logic                 start,
   output logic [WIDTH-1:0]     count,
   output logic [NCH-1:0]       int_match,
   output logic                 int_ovf,
   output logic [NCH-1:0]       io
);
   logic [9:0]       div;
   logic [2:0]       sync;
   logic [WIDTH-1:0] act [NCH];
   logic [WIDTH-1:0] nxt;
   logic [NCH-1:0]   hit, io_nxt;
   logic             down, halted, raw_tick, tick, bottom;

   // sync[1:0] is the two-flop synchronizer, sync[2] the edge-detect history
   always_comb begin
      raw_tick = 1'b0;
      case (clk_source)
         3'd1:    raw_tick = 1'b1;
         3'd2:    raw_tick = &div[2:0];
         3'd3:    raw_tick = &div[5:0];
         3'd4:    raw_tick = &div[7:0];
         3'd5:    raw_tick = &div;
         3'd6:    raw_tick = sync[1] & ~sync[2];
         3'd7:    raw_tick = ~sync[1] & sync[2];
         default: raw_tick = 1'b0;
      endcase
   end

   // a halted one-shot or a load swallows the tick, so no events fire on those cycles
   assign tick = raw_tick & ~halted & ~load;

   // up/down turns around on TOP and holds at 0 when TOP is 0
   assign nxt = (timer_mode == 2'd3) ? ((down | hit[0]) ? ((count == '0) ? '0 : count - WIDTH'(1)) : count + WIDTH'(1)) :
                (timer_mode != 2'd0 && hit[0]) ? '0 : count + WIDTH'(1);

   assign bottom = tick & (nxt == '0);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [1:0] om;
      logic       ev, base;
      assign om        = output_mode[2*i +: 2];
      assign hit[i]    = count == act[i];
      assign ev        = tick & hit[i];
      assign base      = bottom ? (om == 2'd2) : io[i];
      // match action wins over bottom action; down-count matches invert it
      assign io_nxt[i] = (om == 2'd0) ? 1'b0 :
                         (om == 2'd1) ? io[i] ^ ev :
                         ev ? ((om == 2'd3) ^ down) : base;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div       <= '0;
         sync      <= '0;
         count     <= '0;
         down      <= 1'b0;
         halted    <= 1'b0;
         io        <= '0;
         int_match <= '0;
         int_ovf   <= 1'b0;
         for (int k = 0; k < NCH; k++) act[k] <= '0;
      end else begin
         div       <= div + 10'd1;
         sync      <= {sync[1:0], ext_clk};
         io        <= io_nxt;
         int_match <= hit & {NCH{tick}};
         int_ovf   <= bottom;
         // modes 1/3 shadow the compare values until bottom so PWM periods stay glitch-free
         for (int k = 0; k < NCH; k++)
            if (load | ~timer_mode[0] | bottom) act[k] <= match[k*WIDTH +: WIDTH];
         if (load) begin
            count  <= load_value;
            down   <= 1'b0;
            halted <= 1'b0;
         end else begin
            if (start) halted <= 1'b0;
            if (tick) begin
               count <= nxt;
               down  <= (timer_mode == 2'd3) & (nxt != '0) & (down | hit[0]);
               if (timer_mode == 2'd2 && hit[0]) halted <= 1'b1;
            end
            if (timer_mode != 2'd3) down <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hs32_timer_mc.sv
// tb_hs32_timer_mc: directed and randomized checks of hs32_timer_mc (WIDTH=8, NCH=2)
module tb_hs32_timer_mc;
   localparam int W  = 8;
   localparam int N  = 2;
   localparam int MX = 256;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [2:0]     clk_source = '0;
   logic           ext_clk = 1'b0;
   logic [1:0]     timer_mode = '0;
   logic [2*N-1:0] output_mode = '0;
   logic [W*N-1:0] match = '0;
   logic           load = 1'b0;
   logic [W-1:0]   load_value = '0;
   logic           start = 1'b0;
   logic [W-1:0]   count;
   logic [N-1:0]   int_match;
   logic           int_ovf;
   logic [N-1:0]   io;

   int total = 0;
   int bad = 0;

   hs32_timer_mc #(.WIDTH(W), .NCH(N)) dut (
      .clk(clk), .rst_n(rst_n), .clk_source(clk_source), .ext_clk(ext_clk),
      .timer_mode(timer_mode), .output_mode(output_mode), .match(match),
      .load(load), .load_value(load_value), .start(start),
      .count(count), .int_match(int_match), .int_ovf(int_ovf), .io(io)
   );

   always #5 clk = ~clk;

   // reference model state: cycle count since reset, ext_clk sample history, timer state
   int       m_cyc, m_cnt;
   int       m_am [N];
   bit       m_e1, m_e2, m_e3, m_dn, m_halt, m_ovf;
   bit [1:0] m_io, m_im;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      m_cyc = 0; m_cnt = 0; m_e1 = 0; m_e2 = 0; m_e3 = 0;
      m_dn = 0; m_halt = 0; m_ovf = 0; m_io = 0; m_im = 0;
      for (int i = 0; i < N; i++) m_am[i] = 0;
   endtask

   // one clock of the timer from the rules: evaluated with the inputs the DUT samples next edge
   task automatic model_step();
      bit raw, tk, bot, dn0;
      bit [1:0] hit;
      int nx, om;
      case (clk_source)
         3'd1:    raw = 1;
         3'd2:    raw = (m_cyc % 8) == 7;
         3'd3:    raw = (m_cyc % 64) == 63;
         3'd4:    raw = (m_cyc % 256) == 255;
         3'd5:    raw = (m_cyc % 1024) == 1023;
         3'd6:    raw = m_e2 && !m_e3;
         3'd7:    raw = !m_e2 && m_e3;
         default: raw = 0;
      endcase
      m_cyc = (m_cyc + 1) % 1024;
      m_e3 = m_e2; m_e2 = m_e1; m_e1 = ext_clk;
      hit = 0; bot = 0; dn0 = m_dn;
      if (load) begin
         m_cnt = int'(load_value); m_dn = 0; m_halt = 0;
      end else begin
         tk = raw && !m_halt;
         if (start) m_halt = 0;
         if (tk) begin
            for (int i = 0; i < N; i++) hit[i] = (m_cnt == m_am[i]);
            if (timer_mode == 0) nx = (m_cnt + 1) % MX;
            else if (timer_mode != 3) nx = hit[0] ? 0 : (m_cnt + 1) % MX;
            else if (m_dn || hit[0]) nx = (m_cnt > 0) ? m_cnt - 1 : 0;
            else nx = (m_cnt + 1) % MX;
            bot = (nx == 0);
            if (timer_mode == 3) begin
               if (!m_dn && hit[0] && m_cnt > 1) m_dn = 1;
               else if (nx == 0) m_dn = 0;
            end
            if (timer_mode == 2 && hit[0]) m_halt = 1;
            for (int i = 0; i < N; i++) begin
               om = int'(output_mode[2*i +: 2]);
               if (om == 1 && hit[i]) m_io[i] = !m_io[i];
               if (om >= 2) begin
                  if (bot) m_io[i] = (om == 2);
                  if (hit[i]) m_io[i] = dn0 ? (om == 2) : (om == 3);
               end
            end
            m_cnt = nx;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (output_mode[2*i +: 2] == 2'd0) m_io[i] = 0;
         if (load || timer_mode == 0 || timer_mode == 2 || bot) m_am[i] = int'(match[W*i +: W]);
      end
      if (timer_mode != 3) m_dn = 0;
      m_im = hit;
      m_ovf = bot;
   endtask

   task automatic test_reset();
      clk_source = 3'd1; timer_mode = 2'd0; output_mode = 4'b0101; match = '0;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         total++;
         if (count !== 8'd0 || int_match !== 2'b00 || int_ovf !== 1'b0 || io !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold count=%0d int_match=%b int_ovf=%b io=%b required all 0", count, int_match, int_ovf, io);
         end
      end
      rst_n = 1'b1;
      cyc(1);
      total++;
      if (count !== 8'd1) begin
         bad++;
         $display("FAIL first_tick count=%0d required 1", count);
      end
   endtask

   task automatic test_free_run();
      clk_source = 3'd1; timer_mode = 2'd0; output_mode = '0; match = '0;
      apply_reset();
      cyc(255);
      total++;
      if (count !== 8'd255 || int_ovf !== 1'b0) begin
         bad++;
         $display("FAIL free_run_top count=%0d int_ovf=%b required 255/0", count, int_ovf);
      end
      cyc(1);
      total++;
      if (count !== 8'd0 || int_ovf !== 1'b1) begin
         bad++;
         $display("FAIL free_run_wrap count=%0d int_ovf=%b required 0/1", count, int_ovf);
      end
      cyc(1);
      total++;
      if (count !== 8'd1 || int_ovf !== 1'b0) begin
         bad++;
         $display("FAIL free_run_after count=%0d int_ovf=%b required 1/0", count, int_ovf);
      end
   endtask

   task automatic test_pwm();
      int ce;
      bit ioe, ime, ove;
      clk_source = 3'd2; timer_mode = 2'd1; output_mode = 4'b1000; match = {8'd2, 8'd4};
      apply_reset();
      load = 1'b1; load_value = '0;
      cyc(1);
      load = 1'b0;
      for (int n = 2; n <= 240; n++) begin
         cyc(1);
         ce  = (n / 8) % 5;
         ioe = (n >= 40) && (ce <= 2);
         ime = (n % 8 == 0) && (ce == 3);
         ove = (n % 8 == 0) && (ce == 0);
         total++;
         if (count !== W'(ce) || io[1] !== ioe || int_match[1] !== ime || int_ovf !== ove) begin
            bad++;
            $display("FAIL pwm n=%0d count=%0d io1=%b im1=%b ovf=%b required %0d/%b/%b/%b",
                     n, count, io[1], int_match[1], int_ovf, ce, ioe, ime, ove);
         end
      end
   endtask

   task automatic test_one_shot();
      int ce;
      clk_source = 3'd1; timer_mode = 2'd2; output_mode = '0; match = {8'd0, 8'd3};
      apply_reset();
      load = 1'b1; load_value = '0;
      cyc(1);
      load = 1'b0;
      for (int n = 2; n <= 18; n++) begin
         if (n == 11) start = 1'b1;
         cyc(1);
         start = 1'b0;
         ce = (n >= 2 && n <= 4) ? n - 1 : (n >= 12 && n <= 14) ? n - 11 : 0;
         total++;
         if (count !== W'(ce) || int_ovf !== (n == 5 || n == 15)) begin
            bad++;
            $display("FAIL one_shot n=%0d count=%0d ovf=%b required %0d/%b", n, count, int_ovf, ce, (n == 5 || n == 15));
         end
      end
   endtask

   task automatic test_updown();
      int p, ce;
      bit ioe, ove;
      clk_source = 3'd1; timer_mode = 2'd3; output_mode = 4'b1000; match = {8'd1, 8'd3};
      apply_reset();
      load = 1'b1; load_value = '0;
      cyc(1);
      load = 1'b0;
      for (int n = 2; n <= 31; n++) begin
         cyc(1);
         p   = (n - 1) % 6;
         ce  = (p <= 3) ? p : 6 - p;
         ioe = (n >= 7) && (p <= 1);
         ove = (n >= 7) && (p == 0);
         total++;
         if (count !== W'(ce) || io[1] !== ioe || int_ovf !== ove) begin
            bad++;
            $display("FAIL updown n=%0d count=%0d io1=%b ovf=%b required %0d/%b/%b", n, count, io[1], int_ovf, ce, ioe, ove);
         end
      end
   endtask

   task automatic test_shadow();
      int ce;
      clk_source = 3'd1; timer_mode = 2'd1; output_mode = '0; match = {8'd0, 8'd4};
      apply_reset();
      load = 1'b1; load_value = '0;
      cyc(1);
      load = 1'b0;
      for (int n = 2; n <= 16; n++) begin
         if (n == 4) match = {8'd0, 8'd8};
         cyc(1);
         ce = (n <= 5) ? n - 1 : (n == 6 || n == 15) ? 0 : (n <= 14) ? n - 6 : 1;
         total++;
         if (count !== W'(ce) || int_ovf !== (n == 6 || n == 15)) begin
            bad++;
            $display("FAIL shadow n=%0d count=%0d ovf=%b required %0d/%b", n, count, int_ovf, ce, (n == 6 || n == 15));
         end
      end
   endtask

   task automatic test_load_priority();
      clk_source = 3'd1; timer_mode = 2'd1; output_mode = 4'b1100; match = {8'd5, 8'd20};
      apply_reset();
      load = 1'b1; load_value = '0;
      cyc(1);
      load = 1'b0;
      cyc(5);
      total++;
      if (count !== 8'd5) begin
         bad++;
         $display("FAIL load_setup count=%0d required 5", count);
      end
      load = 1'b1; load_value = 8'd7;
      cyc(1);
      load = 1'b0;
      total++;
      if (count !== 8'd7 || int_match !== 2'b00 || int_ovf !== 1'b0 || io !== 2'b00) begin
         bad++;
         $display("FAIL load_priority count=%0d int_match=%b ovf=%b io=%b required 7/00/0/00", count, int_match, int_ovf, io);
      end
      cyc(20);
      total++;
      if (count !== 8'd6 || int_match !== 2'b10 || io !== 2'b10) begin
         bad++;
         $display("FAIL load_resume count=%0d int_match=%b io=%b required 6/10/10", count, int_match, io);
      end
      cyc(3);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (count !== 8'd0 || int_match !== 2'b00 || int_ovf !== 1'b0 || io !== 2'b00) begin
         bad++;
         $display("FAIL async_reset count=%0d int_match=%b ovf=%b io=%b required all 0", count, int_match, int_ovf, io);
      end
      @(negedge clk);
   endtask

   task automatic test_ext_clk();
      int exp [4] = '{0, 0, 1, 1};
      clk_source = 3'd6; timer_mode = 2'd0; output_mode = '0; match = '0; ext_clk = 1'b0;
      apply_reset();
      cyc(2);
      ext_clk = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         total++;
         if (count !== W'(exp[k])) begin
            bad++;
            $display("FAIL ext_rise edge+%0d count=%0d required %0d", k + 1, count, exp[k]);
         end
      end
      ext_clk = 1'b0; clk_source = 3'd7;
      cyc(2);
      total++;
      if (count !== 8'd1) begin
         bad++;
         $display("FAIL ext_fall_early count=%0d required 1", count);
      end
      cyc(1);
      total++;
      if (count !== 8'd2) begin
         bad++;
         $display("FAIL ext_fall count=%0d required 2", count);
      end
   endtask

   task automatic randomize_cfg();
      int r;
      r = $urandom_range(0, 9);
      clk_source  = (r <= 4) ? 3'd1 : (r == 5) ? 3'd2 : (r == 6) ? 3'd6 : (r == 7) ? 3'd7 : (r == 8) ? 3'd3 : 3'd0;
      timer_mode  = 2'($urandom_range(0, 3));
      output_mode = 4'($urandom);
      for (int i = 0; i < N; i++) match[W*i +: W] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
   endtask

   task automatic test_random();
      int shown = 0;
      randomize_cfg();
      load = 1'b0; start = 1'b0;
      apply_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c == 2000) begin
            apply_reset();
            model_reset();
         end
         if (c % 250 == 0) randomize_cfg();
         if (c % 97 == 0) match[W*($urandom_range(0, 1)) +: W] = 8'($urandom_range(0, 15));
         load       = ($urandom_range(0, 49) == 0);
         load_value = 8'($urandom_range(0, 20));
         start      = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 2) == 0) ext_clk = ~ext_clk;
         model_step();
         cyc(1);
         total++;
         if (count !== W'(m_cnt) || int_match !== m_im || int_ovf !== m_ovf || io !== m_io) begin
            bad++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random c=%0d count=%0d im=%b ovf=%b io=%b required %0d/%b/%b/%b",
                        c, count, int_match, int_ovf, io, m_cnt, m_im, m_ovf, m_io);
            end
         end
      end
      load = 1'b0; start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_pwm();
      test_one_shot();
      test_updown();
      test_shadow();
      test_load_priority();
      test_ext_clk();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
